counter_sched: RTL and testbench

- Scheduler that shares one loadable 3-bit delay counter between NREQ requesters.
- Each requester asks for a delay of V counts. The block arbitrates round-robin, loads the counter, enables counting, waits for the counter's done flag, then returns a one-cycle done pulse to the winner.
- Sits between requester FSMs and the counter instance; it is the only driver of the counter's ldEn, value and cEn.

---
 rtl/counter_sched_pkg.sv | 21 ++
 rtl/counter_sched_if.sv | 40 ++++
 rtl/counter_sched_rr_pick.sv | 30 +++
 rtl/counter_sched.sv | 135 +++++++++++++
 tb/tb_counter_sched.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter scheduler.
// The watchdog limit is used only when SCHED_TIMEOUT_EN is defined.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_VW = 3;

    // A healthy counter finishes within 2^VW counts plus its done latency.
    function automatic int wd_limit(input int vw);
        return (1 << vw) + 2;
    endfunction

    localparam int DEF_WD_LIMIT = wd_limit(DEF_VW);

endpackage

// File: rtl/counter_sched_if.sv
// Requester and counter-side signal bundle for counter_sched.
// toErr exists only when SCHED_TIMEOUT_EN is defined.
interface counter_sched_if #(
    parameter int NREQ = 4,
    parameter int VW   = counter_sched_pkg::DEF_VW
);
    // Handshake: a requester raises req[i] with reqVal[i*VW +: VW] and keeps it
    // high until done[i] pulses for one cycle; grant is the one-hot owner while
    // a job runs. ldEn/value/cEn drive the counter, cDone is its registered flag.
    logic [NREQ-1:0]    req;
    logic [NREQ*VW-1:0] reqVal;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic               ldEn;
    logic [VW-1:0]      value;
    logic               cEn;
    logic               cDone;
`ifdef SCHED_TIMEOUT_EN
    logic               toErr;
`endif

    // master: requesters plus the counter instance; slave: the scheduler.
    modport master (
        output req, reqVal, cDone,
        input  grant, done, busy, ldEn, value, cEn
`ifdef SCHED_TIMEOUT_EN
        , input toErr
`endif
    );

    modport slave (
        input  req, reqVal, cDone,
        output grant, done, busy, ldEn, value, cEn
`ifdef SCHED_TIMEOUT_EN
        , output toErr
`endif
    );

endinterface

// File: rtl/counter_sched_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// scanning upward and wrapping. Reusable by other shared-resource schedulers.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        // Pass 0 covers indices at/after the pointer, pass 1 the wrapped ones.
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!o_valid && i_req[j] && ((pass == 0) == (j >= int'(i_ptr)))) begin
                    o_valid     = 1'b1;
                    o_onehot[j] = 1'b1;
                    o_idx       = j[IW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one loadable delay counter between NREQ requesters.
// Optional watchdog and toErr output enabled by defining SCHED_TIMEOUT_EN.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int VW   = DEF_VW,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    counter_sched_if.slave    bus,
    output state_t            o_dbg_state
);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [IW-1:0]   r_id, w_id_nxt;
    logic [VW-1:0]   r_val, w_val_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;

    logic [VW-1:0]   w_req_val [NREQ];
    logic [NREQ-1:0] w_pick_oh;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_valid;

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_LIMIT = wd_limit(VW);
    localparam int WDW      = VW + 2;
    logic [WDW-1:0]  r_wd, w_wd_nxt;
    logic            r_to, w_to_nxt;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_req_val[i] = bus.reqVal[i*VW +: VW];
        end
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_val   <= '0;
            r_grant <= '0;
`ifdef SCHED_TIMEOUT_EN
            r_wd    <= '0;
            r_to    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_id    <= w_id_nxt;
            r_val   <= w_val_nxt;
            r_grant <= w_grant_nxt;
`ifdef SCHED_TIMEOUT_EN
            r_wd    <= w_wd_nxt;
            r_to    <= w_to_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_id_nxt    = r_id;
        w_val_nxt   = r_val;
        w_grant_nxt = r_grant;
`ifdef SCHED_TIMEOUT_EN
        w_wd_nxt    = r_wd;
        w_to_nxt    = r_to;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_id_nxt    = w_pick_idx;
                    w_val_nxt   = w_req_val[w_pick_idx];
                    w_grant_nxt = w_pick_oh;
                    // A zero delay skips the counter: loading 0 would wrap to 2^VW counts.
                    w_state_nxt = (w_req_val[w_pick_idx] != '0) ? LOAD : RESP;
                end
            end
            LOAD: begin
                w_state_nxt = COUNT;
`ifdef SCHED_TIMEOUT_EN
                w_wd_nxt    = '0;
`endif
            end
            COUNT: begin
                if (bus.cDone) begin
                    w_state_nxt = RESP;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (r_wd == WDW'(WD_LIMIT - 1)) begin
                    w_state_nxt = RESP;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
`endif
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_ptr_nxt   = (r_id == IW'(NREQ - 1)) ? '0 : r_id + 1'b1;
`ifdef SCHED_TIMEOUT_EN
                w_to_nxt    = 1'b0;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.grant = r_grant;
    assign bus.done  = (r_state == RESP) ? r_grant : '0;
    assign bus.busy  = (r_state != IDLE);
    assign bus.ldEn  = (r_state == LOAD);
    assign bus.value = r_val;
    // Gated by cDone so the counter does not step once more on the cycle done is seen.
    assign bus.cEn   = (r_state == COUNT) && !bus.cDone;
`ifdef SCHED_TIMEOUT_EN
    assign bus.toErr = (r_state == RESP) && r_to;
`endif
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus randomized jobs checked
// against a transaction-level round-robin/latency model; includes a counter model.
module tb_counter_sched;
    import counter_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int VW   = 3;
    localparam int W    = NREQ * VW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    counter_sched_if #(.NREQ(NREQ), .VW(VW)) bus();
    state_t dbg_state;

    counter_sched #(.NREQ(NREQ), .VW(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [NREQ-1:0] req_drv;
    logic [W-1:0]    reqval_drv;
    logic            cdone_kill;
    int              model_ptr;
    int              n_checks;
    int              n_fail;

    // Loadable down-counter standing in for the shared counter instance.
    logic [VW-1:0] cnt;
    logic          cdone_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            cdone_r <= 1'b0;
        end else if (bus.ldEn) begin
            cnt     <= bus.value;
            cdone_r <= 1'b0;
        end else if (bus.cEn) begin
            cnt     <= cnt - 1'b1;
            cdone_r <= (cnt == VW'(1));
        end
    end

    assign bus.req    = req_drv;
    assign bus.reqVal = reqval_drv;
    assign bus.cDone  = cdone_r & ~cdone_kill;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int get_val(input int j);
        logic [W-1:0] t;
        t = reqval_drv >> (j * VW);
        return int'(t[VW-1:0]);
    endfunction

    task automatic set_val(input int j, input int v);
        logic [W-1:0] m;
        m = W'((1 << VW) - 1) << (j * VW);
        reqval_drv = (reqval_drv & ~m) | ((W'(v) << (j * VW)) & m);
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (((r >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_drv = '0;
        #1;
        check_eq("rst_outputs", {bus.busy, bus.grant, bus.done, bus.ldEn, bus.cEn, bus.value}, 0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Starts at the negedge of an IDLE cycle (cycle 0) with requests applied.
    task automatic run_job(input bit hold, input bit drop_mid, input bit perturb);
        int win, v, cyc, ld_cnt, ld_cyc, cen_cnt, bad, done_cyc;
        logic [NREQ-1:0] exp_oh, done_seen;
        logic to_seen;
        win = model_pick(req_drv, model_ptr);
        if (win < 0) return;
        v = get_val(win);
        exp_oh = NREQ'(1) << win;
        ld_cnt = 0; ld_cyc = -1; cen_cnt = 0; bad = 0; done_cyc = -1;
        done_seen = '0; to_seen = 1'b0;
        check_eq("idle_busy", 32'(bus.busy), 0);
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ldEn) begin
                ld_cnt++;
                if (ld_cyc < 0) ld_cyc = cyc;
            end
            if (bus.cEn) cen_cnt++;
            if (bus.grant !== exp_oh || bus.busy !== 1'b1 || bus.value !== VW'(v)) bad++;
            if (bus.done !== '0) begin
                done_cyc  = cyc;
                done_seen = bus.done;
`ifdef SCHED_TIMEOUT_EN
                to_seen   = bus.toErr;
`endif
                break;
            end
            if (cyc == 1 && perturb) set_val(win, $urandom_range(0, (1 << VW) - 1));
            if (cyc == 2 && drop_mid) req_drv = req_drv & ~exp_oh;
            if (cyc == 2 && perturb && $urandom_range(0, 3) == 0) begin
                int j;
                j = $urandom_range(0, NREQ - 1);
                req_drv = req_drv | (NREQ'(1) << j);
                set_val(j, $urandom_range(0, (1 << VW) - 1));
            end
        end
        check_eq("done_vec", done_seen, exp_oh);
        check_eq("done_cycle", done_cyc, (v == 0) ? 1 : v + 3);
        check_eq("ld_count", ld_cnt, (v != 0) ? 1 : 0);
        check_eq("ld_cycle", ld_cyc, (v != 0) ? 1 : -1);
        check_eq("cen_count", cen_cnt, v);
        check_eq("grant_busy_value_bad_cycles", bad, 0);
        check_eq("to_err_normal", 32'(to_seen), 0);
        model_ptr = (win + 1) % NREQ;
        if (!hold) req_drv = req_drv & ~exp_oh;
        @(posedge clk);
        @(negedge clk);
        check_eq("idle_gap", {bus.busy, bus.grant, bus.done}, 0);
        check_eq("idle_gap_state", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int cen_cnt;
        req_drv    = '0;
        reqval_drv = '0;
        cdone_kill = 1'b0;
        model_ptr  = 0;
        n_checks   = 0;
        n_fail     = 0;

        // Single job, value 3.
        do_reset();
        req_drv = 4'b0001;
        set_val(0, 3);
        run_job(0, 0, 0);

        // Zero-length job never touches the counter.
        req_drv = 4'b0100;
        set_val(2, 0);
        run_job(0, 0, 0);

        // All requesting with value 1: grants 0,1,2,3,0.
        do_reset();
        req_drv = 4'b1111;
        for (int j = 0; j < NREQ; j++) set_val(j, 1);
        for (int n = 0; n < 5; n++) run_job(1, 0, 0);
        req_drv = '0;

        // Reset asserted mid-COUNT.
        do_reset();
        req_drv = 4'b0001;
        set_val(0, 7);
        cen_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.cEn) cen_cnt++;
        end
        check_eq("midcount_state", 32'(dbg_state), 32'(COUNT));
        check_eq("midcount_cen", cen_cnt, 4);
        rst = 1'b1;
        #1;
        check_eq("async_rst_drop", {bus.busy, bus.grant, bus.done, bus.cEn, bus.ldEn}, 0);
        req_drv = '0;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        req_drv = 4'b0010;
        set_val(1, 2);
        run_job(0, 0, 0);

        // Owner drops req during COUNT; waiting requester is served next.
        do_reset();
        req_drv = 4'b0011;
        set_val(0, 2);
        set_val(1, 1);
        run_job(0, 1, 0);
        run_job(0, 0, 0);

        // Randomized rounds.
        for (int round = 0; round < 12; round++) begin
            req_drv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int j = 0; j < NREQ; j++) set_val(j, $urandom_range(0, (1 << VW) - 1));
            for (int n = 0; n < 12 && req_drv != '0; n++) begin
                run_job(0, $urandom_range(0, 3) == 0, 1);
            end
            req_drv = '0;
        end

`ifdef SCHED_TIMEOUT_EN
        // Counter never reports done: watchdog ends the job after 10 COUNT cycles.
        begin
            int done_cyc;
            logic to_seen;
            do_reset();
            cdone_kill = 1'b1;
            req_drv = 4'b0001;
            set_val(0, 5);
            done_cyc = -1;
            to_seen = 1'b0;
            cen_cnt = 0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.cEn) cen_cnt++;
                if (bus.done !== '0) begin
                    done_cyc = c;
                    to_seen = bus.toErr;
                    break;
                end
            end
            check_eq("timeout_done_cycle", done_cyc, 12);
            check_eq("timeout_to_err", 32'(to_seen), 1);
            check_eq("timeout_cen_count", cen_cnt, 10);
            req_drv = '0;
            cdone_kill = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq("timeout_to_err_clear", 32'(bus.toErr), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
